abcd_stepper: RTL

Upstream stimulus stage for the lab3 four-input combinational function block. It debounces a raw push-button and advances a 4-bit combination counter that drives the block's `a`, `b`, `c` and `d` inputs, so the full truth table can be walked by hand on the board. It also provides a clear input, a wrap indication, and an optional free-running auto-step mode.

---
 rtl/abcd_stepper.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/abcd_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : abcd_stepper
//  Description : Debounced push-button stepper for the lab3 four-input
//                function block. A 4-bit combination counter drives a/b/c/d
//                (a = MSB). It provides a synchronized clear, a one-cycle
//                step_pulse per advance and a one-cycle wrap on 15 -> 0.
//                Optional feature macro: AUTO_STEP_EN (adds auto_en port and
//                a free-running prescaler that advances every AUTO_DIV
//                cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module abcd_stepper #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DIV        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_step,
    input  logic btn_clear,
`ifdef AUTO_STEP_EN
    input  logic auto_en,
`endif
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic step_pulse,
    output logic wrap
);

    localparam logic [15:0] c_db_last = 16'(DEBOUNCE_CYCLES - 1);

    // Reject out-of-range configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("abcd_stepper: DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (AUTO_DIV < 2 || AUTO_DIV > 65535) begin : g_bad_auto_div
        $error("abcd_stepper: AUTO_DIV out of range 2..65535");
    end

    logic        r_step_s1;
    logic        r_step_s2;
    logic        r_clr_s1;
    logic        r_clr_s2;
    logic        r_db;
    logic [15:0] r_dcnt;
    logic [3:0]  r_cnt;
    logic        r_step_pulse;
    logic        r_wrap;

    logic        w_db_accept;
    logic        w_manual_adv;
    logic        w_auto_adv;
    logic        w_adv;

    // Two-flop synchronizers for both raw button inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
            r_clr_s1  <= 1'b0;
            r_clr_s2  <= 1'b0;
        end else begin
            r_step_s1 <= btn_step;
            r_step_s2 <= r_step_s1;
            r_clr_s1  <= btn_clear;
            r_clr_s2  <= r_clr_s1;
        end
    end

    // The accepted level flips once s2 has disagreed with it for
    // DEBOUNCE_CYCLES consecutive edges; only the rising flip advances.
    assign w_db_accept  = (r_step_s2 != r_db) && (r_dcnt == c_db_last);
    assign w_manual_adv = w_db_accept && r_step_s2;

    // Debounce counter; keeps running through clear so a held press cannot
    // re-trigger when clear is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db   <= 1'b0;
            r_dcnt <= 16'd0;
        end else if (r_step_s2 != r_db) begin
            if (w_db_accept) begin
                r_db   <= r_step_s2;
                r_dcnt <= 16'd0;
            end else begin
                r_dcnt <= r_dcnt + 16'd1;
            end
        end else begin
            r_dcnt <= 16'd0;
        end
    end

`ifdef AUTO_STEP_EN
    localparam logic [15:0] c_auto_last = 16'(AUTO_DIV - 1);

    logic [15:0] r_presc;

    assign w_auto_adv = auto_en && (r_presc == c_auto_last);

    // Prescaler: counts 0..AUTO_DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n || r_clr_s2 || !auto_en) begin
            r_presc <= 16'd0;
        end else if (w_auto_adv) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end
`else
    assign w_auto_adv = 1'b0;
`endif

    // Coincident manual and auto events collapse into a single advance.
    assign w_adv = w_manual_adv || w_auto_adv;

    // Combination counter with registered step and wrap indications.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_step_pulse <= 1'b0;
            r_wrap       <= 1'b0;
        end else if (r_clr_s2) begin
            r_cnt        <= 4'd0;
            r_step_pulse <= 1'b0;
            r_wrap       <= 1'b0;
        end else if (w_adv) begin
            r_cnt        <= r_cnt + 4'd1;
            r_step_pulse <= 1'b1;
            r_wrap       <= (r_cnt == 4'hF);
        end else begin
            r_step_pulse <= 1'b0;
            r_wrap       <= 1'b0;
        end
    end

    assign {a, b, c, d} = r_cnt;
    assign step_pulse   = r_step_pulse;
    assign wrap         = r_wrap;

endmodule
`default_nettype wire
